ahb_subordinate_mem: RTL and testbench
======================================

// Module: ahb_subordinate_mem
// PURPOSE
//  AHB-Lite subordinate (responder) with a byte-addressed local memory. It sits on the
//    subordinate side of the bus that the AVIP master drives, and gives the master agent
//    a real RTL target.
//  Accepts pipelined address/data phases and inserts a programmable number of wait states.
//  Returns OKAY, or the two-cycle ERROR response, for every transfer.
// PARAMETERS
//  ADDR_WIDTH      32  haddr width
//  DATA_WIDTH      32  hwdata/hrdata width (32 or 64)
//  MEM_ADDR_BITS   12  local memory = 2**MEM_ADDR_BITS bytes, decoded from haddr[MEM_ADDR_BITS-1:0]
//  BASE_ADDR       0   region base; haddr outside [BASE_ADDR, BASE_ADDR+2**MEM_ADDR_BITS) -> ERROR
//  WAIT_STATES     0   wait cycles (0..15) inserted into every OKAY NONSEQ/SEQ data phase
// PORTS
//  hclk       in   1             bus clock, all state on rising edge
//  hresetn    in   1             asynchronous active-low reset
//  hselx      in   1             subordinate select
//  haddr      in   ADDR_WIDTH    transfer address
//  htrans     in   2             IDLE/BUSY/NONSEQ/SEQ
//  hwrite     in   1             1 = write, 0 = read
//  hsize      in   3             transfer size (BYTE..DOUBLEWORD)
//  hburst     in   3             burst type; sampled, no functional effect
//  hprot      in   4             protection; used only under AHB_SUB_PROT_CHECK_EN
//  hwdata     in   DATA_WIDTH    write data, valid in data phase
//  hready     in   1             combined bus ready
//  hreadyout  out  1             subordinate ready
//  hresp      out  1             0 = OKAY, 1 = ERROR
//  hrdata     out  DATA_WIDTH    read data, valid when hreadyout=1 in a read data phase
// BEHAVIOUR
//  Reset values: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0.
//    Memory contents are not reset.
//  Address phase acceptance
//    - Accept when hselx & hready & htrans is NONSEQ or SEQ.
//    - On acceptance, register haddr, hwrite and hsize.
//    - hselx & hready & htrans is IDLE or BUSY -> zero-wait OKAY, no memory access.
//  ERROR check (at acceptance): address out of range, haddr misaligned to hsize,
//    or 8<<hsize > DATA_WIDTH.
//  FSM states, with outputs (hreadyout/hresp) and transitions
//    - IDLE (1/0):
//        accept+ok -> WAIT if WAIT_STATES>0, else DATA;
//        accept+err -> ERR1.
//    - WAIT (0/0): counter loads WAIT_STATES-1 on entry; -> DATA when the counter is 0.
//    - DATA (1/0): data phase completes this cycle.
//        Back-to-back accept follows the same rules as IDLE; no accept -> IDLE.
//    - ERR1 (0/1): -> ERR2 unconditionally.
//    - ERR2 (1/1): accept follows the IDLE rules (master may cancel with IDLE).
//  Write: byte lanes selected by the registered haddr low bits and hsize (little-endian).
//    Memory is updated at the clock edge that ends DATA. Writes in ERR states are dropped.
//  Read: hrdata driven from memory at the registered address during DATA, placed on the
//    correct byte lanes; unused lanes are 0.
//  Read immediately after write to the same address returns the new data.
//  hresetn low at any point, including mid-WAIT/ERR: return to reset values at once,
//    with no pending write committed.
// CONFIGURATION
//  AHB_SUB_PROT_CHECK_EN defined:
//    - Access to the upper half of memory with hprot[1]=0 (unprivileged) -> ERROR.
//  Undefined:
//    - hprot is ignored.
// STRUCTURE
//  ahb_sub_pkg holds:
//    - htrans/hsize/hresp localparams
//    - FSM state enum {IDLE, WAIT, DATA, ERR1, ERR2}
//    - function size_ok(hsize, haddr)
//  Sub-module ahb_sub_lane_decode: (haddr[2:0], hsize) -> byte-strobe vector;
//    the same vector is used for both the write mask and read lane steering.
// TESTING
//  1. WAIT_STATES=0: WORD write 0xDEADBEEF @0x10, then read @0x10
//       -> hreadyout never low; hrdata=0xDEADBEEF, hresp=0.
//  2. WAIT_STATES=3: single NONSEQ read
//       -> hreadyout low for exactly 3 cycles, then 1 for 1 cycle.
//  3. BYTE writes 0x11,0x22 @0x21,0x22, then WORD read @0x20
//       -> hrdata=0x00221100 (after first clearing 0x20 to 0).
//  4. WORD read @0x3 (misaligned) and @BASE_ADDR+0x1000
//       -> ERR1 (hreadyout 0, hresp 1), then ERR2 (1, 1).
//  5. INCR4 write 0x1..0x4 @0x40 with a BUSY inserted, then INCR4 read
//       -> 0x1..0x4 returned, BUSY gets zero-wait OKAY.
//  6. hresetn pulsed during WAIT of a write @0x50
//       -> outputs go to reset values; a later read @0x50 shows the old data.

Source files
------------

// File: rtl/ahb_sub_pkg.sv
// Shared AHB-Lite encodings, subordinate FSM states and the size/alignment helper
// used by ahb_subordinate_mem and its lane decoder.
package ahb_sub_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_e;

  // True when the transfer fits the bus and is naturally aligned.
  function automatic logic size_ok(input logic [2:0] hsize, input logic [2:0] haddr_lo,
                                   input int unsigned dw);
    logic [2:0] mask;
    mask = (3'd1 << hsize) - 3'd1;
    return ((32'd8 << hsize) <= dw) && ((haddr_lo & mask) == 3'd0);
  endfunction

endpackage

// File: rtl/ahb_sub_lane_decode.sv
// Byte-strobe decode from the low address bits and hsize; the same vector masks
// writes and steers read lanes.
module ahb_sub_lane_decode #(
  parameter int NB = 4
) (
  input  logic [2:0]    i_addr_lo,
  input  logic [2:0]    i_size,
  output logic [NB-1:0] o_strb
);

  logic [7:0] w_off;
  logic [7:0] w_end;

  assign w_off = {5'd0, i_addr_lo} & 8'(NB - 1);
  assign w_end = w_off + (8'd1 << i_size);

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign o_strb[b] = (8'(b) >= w_off) && (8'(b) < w_end);
  end

endmodule

// File: rtl/ahb_subordinate_mem.sv
// AHB-Lite subordinate with byte-addressed local memory, programmable wait states and
// two-cycle ERROR. Optional macro AHB_SUB_PROT_CHECK_EN rejects unprivileged upper-half access.
module ahb_subordinate_mem
  import ahb_sub_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    MEM_ADDR_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    WAIT_STATES   = 0
) (
  input  logic                  i_hclk,
  input  logic                  i_hresetn,
  input  logic                  i_hselx,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic [1:0]            i_htrans,
  input  logic                  i_hwrite,
  input  logic [2:0]            i_hsize,
  input  logic [2:0]            i_hburst,
  input  logic [3:0]            i_hprot,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  input  logic                  i_hready,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata
);

  localparam int NB        = DATA_WIDTH / 8;
  localparam int LB        = $clog2(NB);
  localparam int MEM_BYTES = 2 ** MEM_ADDR_BITS;
  localparam logic [ADDR_WIDTH:0] RGN_LO  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] RGN_HI  = RGN_LO + ((ADDR_WIDTH+1)'(1) << MEM_ADDR_BITS);
  localparam logic [3:0]          WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e                   r_state, w_state_nxt;
  logic [3:0]               r_cnt, w_cnt_nxt;
  logic [MEM_ADDR_BITS-1:0] r_addr;
  logic                     r_write;
  logic [2:0]               r_size;
  logic [7:0]               r_mem [MEM_BYTES];

  logic                     w_rdy, w_accept, w_err, w_range_err, w_prot_err;
  logic [NB-1:0]            w_strb;
  logic [MEM_ADDR_BITS-1:0] w_base;
  logic                     w_unused;

  assign w_unused = ^{i_hburst, i_hprot};

  // Only states that drive hreadyout high can end an address phase.
  assign w_rdy    = (r_state == IDLE) || (r_state == DATA) || (r_state == ERR2);
  assign w_accept = i_hselx && i_hready && w_rdy &&
                    ((i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ));

  assign w_range_err = ({1'b0, i_haddr} < RGN_LO) || ({1'b0, i_haddr} >= RGN_HI);
`ifdef AHB_SUB_PROT_CHECK_EN
  assign w_prot_err  = i_haddr[MEM_ADDR_BITS-1] && !i_hprot[1];
`else
  assign w_prot_err  = 1'b0;
`endif
  assign w_err = w_range_err || w_prot_err || !size_ok(i_hsize, i_haddr[2:0], 32'(DATA_WIDTH));

  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_hreadyout = 1'b1;
    o_hresp     = HRESP_OKAY;
    case (r_state)
      WAIT: begin
        o_hreadyout = 1'b0;
        if (r_cnt == 4'd0) w_state_nxt = DATA;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      ERR1: begin
        o_hreadyout = 1'b0;
        o_hresp     = HRESP_ERROR;
        w_state_nxt = ERR2;
      end
      default: begin
        if (r_state == ERR2) o_hresp = HRESP_ERROR;
        if (!w_accept)             w_state_nxt = IDLE;
        else if (w_err)            w_state_nxt = ERR1;
        else if (WAIT_STATES > 0) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = WS_LOAD;
        end else                   w_state_nxt = DATA;
      end
    endcase
  end

  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
    end else if (w_accept) begin
      r_addr  <= i_haddr[MEM_ADDR_BITS-1:0];
      r_write <= i_hwrite;
      r_size  <= i_hsize;
    end
  end

  ahb_sub_lane_decode #(.NB(NB)) u_lane_decode (
    .i_addr_lo (r_addr[2:0]),
    .i_size    (r_size),
    .o_strb    (w_strb)
  );

  assign w_base = {r_addr[MEM_ADDR_BITS-1:LB], {LB{1'b0}}};

  // Commit on the edge that ends DATA; reset forces IDLE so no write can slip through.
  always_ff @(posedge i_hclk) begin
    if (r_state == DATA && r_write)
      for (int b = 0; b < NB; b++)
        if (w_strb[b]) r_mem[w_base + MEM_ADDR_BITS'(b)] <= i_hwdata[8*b +: 8];
  end

  always_comb begin
    o_hrdata = '0;
    if (r_state == DATA && !r_write)
      for (int b = 0; b < NB; b++)
        if (w_strb[b]) o_hrdata[8*b +: 8] = r_mem[w_base + MEM_ADDR_BITS'(b)];
  end

endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// Table-driven plus randomized bench for ahb_subordinate_mem: one instance with no wait
// states, one with three, checked against a byte-array reference model.
module tb_ahb_subordinate_mem;
  import ahb_sub_pkg::*;

  localparam logic [1:0] NS = HTRANS_NONSEQ, SQ = HTRANS_SEQ, BZ = HTRANS_BUSY, ID = HTRANS_IDLE;
  localparam logic [2:0] SB = HSIZE_BYTE, SH = HSIZE_HALF, SW = HSIZE_WORD, SD = HSIZE_DWORD;

  logic        hclk = 1'b0, hresetn = 1'b0;
  logic        hsel0 = 1'b0, hsel3 = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2, hburst = 3'b011;
  logic [3:0]  hprot = 4'b0011;
  logic        ro0, rp0, ro3, rp3;
  logic [31:0] rd0, rd3;

  always #5 hclk = ~hclk;

  ahb_subordinate_mem #(.WAIT_STATES(0)) u_dut0 (
    .i_hclk(hclk), .i_hresetn(hresetn), .i_hselx(hsel0), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hprot(hprot), .i_hwdata(hwdata),
    .i_hready(ro0), .o_hreadyout(ro0), .o_hresp(rp0), .o_hrdata(rd0));

  ahb_subordinate_mem #(.WAIT_STATES(3)) u_dut3 (
    .i_hclk(hclk), .i_hresetn(hresetn), .i_hselx(hsel3), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hprot(hprot), .i_hwdata(hwdata),
    .i_hready(ro3), .o_hreadyout(ro3), .o_hresp(rp3), .o_hrdata(rd3));

  typedef struct {
    bit          d3;
    logic [1:0]  t;
    logic [31:0] a;
    bit          w;
    logic [2:0]  s;
    logic [31:0] wd;
    int          ew;
    bit          er;
    bit          crd;
    logic [31:0] erd;
    string       nm;
  } vec_t;

  int errors = 0, checks = 0;
  vec_t tbl[$];
  vec_t q[$];
  int          gw[$];
  logic        gr[$];
  logic [31:0] gd[$];
  logic [7:0]  mm [0:4095];

  function automatic vec_t v(input bit d3, input logic [1:0] t, input logic [31:0] a,
                             input bit w, input logic [2:0] s, input logic [31:0] wd,
                             input int ew, input bit er, input bit crd,
                             input logic [31:0] erd, input string nm);
    vec_t r;
    r.d3 = d3; r.t = t; r.a = a; r.w = w; r.s = s; r.wd = wd;
    r.ew = ew; r.er = er; r.crd = crd; r.erd = erd; r.nm = nm;
    return r;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Pipelined master: each beat's data phase completes on the first cycle with hready high.
  task automatic run(input bit use3);
    int n, cur, nxt, waits, cyc, budget;
    logic rdy, rsp;
    logic [31:0] rdv;
    n = q.size(); cur = -1; nxt = 0; waits = 0; cyc = 0; budget = 20 * n + 50;
    gw.delete(); gr.delete(); gd.delete();
    @(posedge hclk); #1;
    hsel0 = !use3; hsel3 = use3;
    while ((nxt < n || cur >= 0) && cyc < budget) begin
      if (nxt < n) begin
        htrans = q[nxt].t; haddr = q[nxt].a; hwrite = q[nxt].w; hsize = q[nxt].s;
      end else htrans = ID;
      hwdata = (cur >= 0 && q[cur].w) ? q[cur].wd : 32'h0;
      @(negedge hclk);
      rdy = use3 ? ro3 : ro0;
      rsp = use3 ? rp3 : rp0;
      rdv = use3 ? rd3 : rd0;
      if (rdy) begin
        if (cur >= 0) begin
          gw.push_back(waits); gr.push_back(rsp); gd.push_back(rdv);
        end
        waits = 0;
        if (nxt < n) begin cur = nxt; nxt++; end
        else cur = -1;
      end else waits++;
      @(posedge hclk); #1;
      cyc++;
    end
    if (cyc >= budget) begin
      errors++; checks++;
      $display("FAIL run_timeout beats_done=%0d exp=%0d", gw.size(), n);
    end
    hsel0 = 1'b0; hsel3 = 1'b0; htrans = ID; hwdata = '0;
  endtask

  task automatic check_q();
    checks++;
    if (gw.size() != q.size()) begin
      errors++;
      $display("FAIL beat_count got=%0d exp=%0d", gw.size(), q.size());
    end
    for (int i = 0; i < gw.size() && i < q.size(); i++) begin
      chk32({q[i].nm, "_wait"}, 32'(gw[i]), 32'(q[i].ew));
      chk32({q[i].nm, "_resp"}, {31'd0, gr[i]}, {31'd0, q[i].er});
      if (q[i].crd) chk32({q[i].nm, "_rdata"}, gd[i], q[i].erd);
    end
  endtask

  task automatic run_group(input bit use3);
    q.delete();
    foreach (tbl[i]) if (tbl[i].d3 == use3) q.push_back(tbl[i]);
    run(use3);
    check_q();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [1:0]  t;
    logic [31:0] a, wd, erd;
    logic [2:0]  s;
    bit          w, er, act;
    int          r;

    // Directed vectors: no-wait instance
    tbl.push_back(v(0, NS, 32'h10, 1, SW, 32'hDEADBEEF, 0, 0, 0, 0, "t1_wr"));
    tbl.push_back(v(0, NS, 32'h10, 0, SW, 0, 0, 0, 1, 32'hDEADBEEF, "t1_rd"));
    tbl.push_back(v(0, NS, 32'h20, 1, SW, 32'h0, 0, 0, 0, 0, "t3_clr"));
    tbl.push_back(v(0, NS, 32'h21, 1, SB, 32'h00001100, 0, 0, 0, 0, "t3_wb1"));
    tbl.push_back(v(0, NS, 32'h22, 1, SB, 32'h00220000, 0, 0, 0, 0, "t3_wb2"));
    tbl.push_back(v(0, NS, 32'h20, 0, SW, 0, 0, 0, 1, 32'h00221100, "t3_rdw"));
    tbl.push_back(v(0, NS, 32'h22, 0, SB, 0, 0, 0, 1, 32'h00220000, "t3_rdb"));
    tbl.push_back(v(0, NS, 32'h22, 0, SH, 0, 0, 0, 1, 32'h00220000, "t3_rdh"));
    tbl.push_back(v(0, NS, 32'h3,  0, SW, 0, 1, 1, 0, 0, "t4_misal"));
    tbl.push_back(v(0, NS, 32'h1000, 0, SW, 0, 1, 1, 0, 0, "t4_range"));
    tbl.push_back(v(0, NS, 32'h20, 0, SD, 0, 1, 1, 0, 0, "t4_size"));
    tbl.push_back(v(0, NS, 32'h40, 1, SW, 32'h1, 0, 0, 0, 0, "t5_w0"));
    tbl.push_back(v(0, SQ, 32'h44, 1, SW, 32'h2, 0, 0, 0, 0, "t5_w1"));
    tbl.push_back(v(0, BZ, 32'h48, 1, SW, 32'h0, 0, 0, 0, 0, "t5_busy"));
    tbl.push_back(v(0, SQ, 32'h48, 1, SW, 32'h3, 0, 0, 0, 0, "t5_w2"));
    tbl.push_back(v(0, SQ, 32'h4C, 1, SW, 32'h4, 0, 0, 0, 0, "t5_w3"));
    tbl.push_back(v(0, NS, 32'h40, 0, SW, 0, 0, 0, 1, 32'h1, "t5_r0"));
    tbl.push_back(v(0, SQ, 32'h44, 0, SW, 0, 0, 0, 1, 32'h2, "t5_r1"));
    tbl.push_back(v(0, SQ, 32'h48, 0, SW, 0, 0, 0, 1, 32'h3, "t5_r2"));
    tbl.push_back(v(0, SQ, 32'h4C, 0, SW, 0, 0, 0, 1, 32'h4, "t5_r3"));
    tbl.push_back(v(0, ID, 32'h4C, 0, SW, 0, 0, 0, 0, 0, "idle"));
    tbl.push_back(v(0, NS, 32'hFFC, 1, SW, 32'hCAFEF00D, 0, 0, 0, 0, "top_ww"));
    tbl.push_back(v(0, NS, 32'hFFF, 1, SB, 32'h5A000000, 0, 0, 0, 0, "top_wb"));
    tbl.push_back(v(0, NS, 32'hFFC, 0, SW, 0, 0, 0, 1, 32'h5AFEF00D, "top_rw"));
    tbl.push_back(v(0, NS, 32'hFFF, 0, SB, 0, 0, 0, 1, 32'h5A000000, "top_rb"));
    // Directed vectors: three-wait-state instance
    tbl.push_back(v(1, NS, 32'h0,  0, SW, 0, 3, 0, 0, 0, "t2_rd"));
    tbl.push_back(v(1, NS, 32'h50, 1, SW, 32'hA5A5A5A5, 3, 0, 0, 0, "t6_old_wr"));
    tbl.push_back(v(1, NS, 32'h50, 0, SW, 0, 3, 0, 1, 32'hA5A5A5A5, "t6_old_rd"));
    tbl.push_back(v(1, NS, 32'h52, 0, SW, 0, 1, 1, 0, 0, "ws_misal"));
    tbl.push_back(v(1, BZ, 32'h54, 0, SW, 0, 0, 0, 0, 0, "ws_busy"));

    #3;
    chk32("rst_hreadyout0", {31'd0, ro0}, 32'd1);
    chk32("rst_hresp0",     {31'd0, rp0}, 32'd0);
    chk32("rst_hrdata0",    rd0,          32'd0);
    chk32("rst_hreadyout3", {31'd0, ro3}, 32'd1);
    chk32("rst_hresp3",     {31'd0, rp3}, 32'd0);
    chk32("rst_hrdata3",    rd3,          32'd0);
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;

    run_group(0);
    run_group(1);

    // Reset pulsed while a write sits in WAIT: outputs snap back, write is lost
    @(posedge hclk); #1;
    hsel3 = 1'b1; htrans = NS; haddr = 32'h50; hwrite = 1'b1; hsize = SW;
    @(posedge hclk); #1;
    htrans = ID; hwdata = 32'h12345678;
    @(negedge hclk);
    chk32("t6_in_wait", {31'd0, ro3}, 32'd0);
    @(posedge hclk); #1;
    hresetn = 1'b0;
    #1;
    chk32("t6_rst_hreadyout", {31'd0, ro3}, 32'd1);
    chk32("t6_rst_hresp",     {31'd0, rp3}, 32'd0);
    chk32("t6_rst_hrdata",    rd3,          32'd0);
    @(posedge hclk); #1;
    hresetn = 1'b1; hsel3 = 1'b0; hwdata = '0;
    q.delete();
    q.push_back(v(1, NS, 32'h50, 0, SW, 0, 3, 0, 1, 32'hA5A5A5A5, "t6_after_rd"));
    run(1);
    check_q();

    // Randomized traffic on the no-wait instance against the byte model
    q.delete();
    for (int i = 0; i < 64; i++) begin
      q.push_back(v(0, NS, 32'(i * 4), 1, SW, 32'h0, 0, 0, 0, 0, "init"));
      for (int k = 0; k < 4; k++) mm[i * 4 + k] = 8'h00;
    end
    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 9);
      t  = (r < 5) ? NS : (r < 8) ? SQ : (r == 8) ? BZ : ID;
      s  = ($urandom_range(0, 9) == 0) ? SD : 3'($urandom_range(0, 2));
      a  = ($urandom_range(0, 15) == 0) ? 32'h1000 + 32'($urandom_range(0, 255))
                                        : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      act = (t == NS) || (t == SQ);
      er  = act && ((a >= 32'h1000) || ((a % (32'd1 << s)) != 0) || (s > 3'd2));
      erd = '0;
      if (act && !er) begin
        for (int k = 0; k < (1 << s); k++) begin
          if (w) mm[a + k] = wd[((a + k) % 4) * 8 +: 8];
          else   erd[((a + k) % 4) * 8 +: 8] = mm[a + k];
        end
      end
      q.push_back(v(0, t, a, w, s, wd, er ? 1 : 0, er, act && !er && !w, erd,
                    $sformatf("rnd%0d", i)));
    end
    run(0);
    check_q();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
